// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx among NUM_REQ byte streams.
// Optional stall watchdog enabled by defining UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_busy,
   output logic                 arb_busy,
   output logic                 err_timeout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
      $error("uart_tx_arbiter: illegal parameter value");
   end

   typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_WAIT_HI, S_WAIT_LO} state_t;

   state_t             r_state, w_next;
   logic [IDX_W-1:0]   r_owner, r_rr, w_pick, w_idx;
   logic               w_pick_vld;
   logic [NUM_REQ-1:0] r_grant, r_ready;
   logic [7:0]         r_tx_data;
   logic               r_tx_valid, r_last, r_arb_busy;
   logic               w_own_valid, w_own_last;
   logic               w_accept, w_release, w_timeout, w_tmo_hit;

   assign w_own_valid = req_valid[r_owner];
   assign w_own_last  = req_last[r_owner];

   // First requester after the last owner, wrapping around.
   always_comb begin
      w_pick     = '0;
      w_pick_vld = 1'b0;
      w_idx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = IDX_W'((int'(r_rr) + k) % NUM_REQ);
         if (!w_pick_vld && req_valid[w_idx]) begin
            w_pick     = w_idx;
            w_pick_vld = 1'b1;
         end
      end
   end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_tmo_cnt;
   logic             r_err;

   assign w_tmo_hit = (r_state == S_GRANTED) && !w_own_valid &&
                      (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Counts owner-stall cycles; an owner that is valid but blocked by tx_busy holds the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (r_state != S_GRANTED || w_accept || w_timeout)
            r_tmo_cnt <= '0;
         else if (!w_own_valid)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign err_timeout = r_err;
`else
   assign w_tmo_hit   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_release = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE:    if (w_pick_vld) w_next = S_GRANTED;
         S_GRANTED: begin
            if (w_own_valid && !tx_busy) begin
               w_accept = 1'b1;
               w_next   = S_WAIT_HI;
            end else if (w_tmo_hit) begin
               w_timeout = 1'b1;
               w_next    = S_IDLE;
            end
         end
         S_WAIT_HI: if (tx_busy) w_next = S_WAIT_LO;
         S_WAIT_LO: begin
            if (!tx_busy) begin
               if (r_last) begin
                  w_release = 1'b1;
                  w_next    = S_IDLE;
               end else begin
                  w_next = S_GRANTED;
               end
            end
         end
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_grant    <= '0;
         r_owner    <= '0;
         r_rr       <= IDX_W'(NUM_REQ - 1);
         r_last     <= 1'b0;
         r_tx_data  <= '0;
         r_tx_valid <= 1'b0;
         r_ready    <= '0;
         r_arb_busy <= 1'b0;
      end else begin
         r_tx_valid <= w_accept;
         r_ready    <= w_accept ? (NUM_REQ'(1) << r_owner) : '0;
         r_arb_busy <= (w_next != S_IDLE);
         if (r_state == S_IDLE && w_pick_vld) begin
            r_owner <= w_pick;
            r_grant <= NUM_REQ'(1) << w_pick;
         end
         if (w_accept) begin
            r_tx_data <= req_data[{r_owner, 3'b000} +: 8];
            r_last    <= w_own_last;
         end
         if (w_release || w_timeout) begin
            r_rr    <= r_owner;
            r_grant <= '0;
         end
      end
   end

   assign req_ready = r_ready;
   assign grant     = r_grant;
   assign tx_data   = r_tx_data;
   assign tx_valid  = r_tx_valid;
   assign arb_busy  = r_arb_busy;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between NUM_REQ byte-stream requesters (e.g. FizzBuzz responder, echo path, status reporter).
- Grants whole packets, where a packet is a byte run ending with last=1. Round-robin arbitration is done at packet boundaries only.
- Issues single-cycle tx_valid pulses and paces them on tx_busy.
- Sits between the requester logic and uart_tx in uart_top-style designs.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, stall limit in cycles for the optional watchdog (>=2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  NUM_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of its packet.
- req_ready  output  NUM_REQ  one-hot, 1-cycle pulse: byte consumed.
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- tx_data  output  8  byte to uart_tx.
- tx_valid  output  1  1-cycle start pulse to uart_tx.
- tx_busy  input  1  uart_tx busy.
- arb_busy  output  1  high whenever state != IDLE.
- err_timeout  output  1  1-cycle pulse on watchdog abort; tied 0 without the macro.

Behaviour:
- Reset values:
  - req_ready=0, grant=0, tx_data=0, tx_valid=0, arb_busy=0, err_timeout=0.
  - state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first.
- All outputs are registered.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from (rr+1) mod NUM_REQ upward with wrap-around.
  - Register grant and go to GRANTED.
  - No req_valid: stay in IDLE.
- GRANTED (g = owner):
  - If req_valid[g] && !tx_busy:
    - Capture req_data[g] into tx_data and req_last[g] into last_q.
    - Next cycle tx_valid=1 and req_ready[g]=1, both for exactly one cycle.
    - Go to WAIT_HI.
  - Otherwise hold. The grant is never revoked mid-packet unless the watchdog fires.
- WAIT_HI: stay until tx_busy==1 is sampled, then go to WAIT_LO.
- WAIT_LO: stay until tx_busy==0 is sampled, then:
  - last_q=1: rr<=g, grant<=0, go to IDLE.
  - last_q=0: go to GRANTED.
- Handshake contract:
  - Requester holds req_data, req_last and req_valid stable until it sees req_ready.
  - Requester presents the next byte from the cycle after req_ready.
- Latency: req_valid rising in IDLE → grant 1 cycle later → tx_valid and req_ready 2 cycles later.
- Simultaneous requests: exactly one grant per arbitration. With all requesters continuously requesting, packets alternate strictly 0,1,...,NUM_REQ-1,0.
- A requester raising req_valid while another owns the grant waits. Its request is not lost; it is evaluated at the next IDLE.
- req_valid[g] dropping mid-packet: stay in GRANTED, no output activity.
- tx_busy already high on entry to GRANTED: no pulse is issued until tx_busy falls.
- Reset mid-packet: all state and outputs clear asynchronously.
  - An in-flight tx_valid pulse is truncated.
  - The partial packet is abandoned; the requester restarts its packet.
- Single-byte packet (last on first byte): valid; one pulse, then grant is released.

Optional Feature:
- Macro: UART_TX_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter runs while in GRANTED with req_valid[g]==0; it clears on any accepted byte or on leaving GRANTED.
  - When it reaches TIMEOUT_CYCLES: err_timeout pulses 1 cycle, rr<=g, grant<=0, go to IDLE.
  - The abandoned requester may request again afterwards and is treated as a new packet.
- Undefined: no counter; err_timeout is constant 0; a stalled owner holds the grant forever.

Test Plan:
- Req0 sends "Fizz" (last on 'z' #2) with no other traffic → four tx_valid pulses carrying 0x46,0x69,0x7A,0x7A, each issued only after the prior tx_busy fall; grant=01 throughout, then grant=00 and arb_busy=0.
- Req0 "12" and req1 "Buzz" raised in the same cycle after reset → tx bytes in order '1','2','B','u','z','z'; then req0 re-requests → granted before req1's next packet.
- Req1 mid-packet while req0 sends "34" → no req1 bytes interleaved; req1's first byte starts within 2 cycles of req0's final tx_busy fall.
- Assert rst during WAIT_LO of byte 2 of "Fizz" → all outputs 0 in the same cycle; after release, req0 resends "Fizz" in full, 4 pulses.
- Macro on, TIMEOUT_CYCLES=16: req0 sends 'F' without last, then drops req_valid → err_timeout pulses 16 cycles after entering GRANTED; pending req1 granted 1 cycle later.
- Single-byte packets "0" from req0 and req1, repeated 3 times each → 6 pulses alternating 0,1,0,1,0,1.
